// File: rtl/dmem_responder.sv
// dmem_responder
// ---------------------------------------------------------------------------
// Handshaked data-memory responder: the memory end of the CPU load/store
// interface. It accepts one word request at a time in IDLE, waits
// WAIT_CYCLES cycles in BUSY, and then commits the access. The response is
// held in RESP until the requester takes it.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//   TEST_WORD    word index whose low half is shown on test_value
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset (clears FSM and all memory)
//   req_valid   request present                 req_ready  responder in IDLE
//   req_write   1 = store, 0 = load             req_addr   byte address
//   req_wdata   store data
//   resp_valid  response held in RESP           resp_ready requester takes it
//   resp_rdata  load data (0 for stores/errors) resp_err   misaligned/out of range
//   test_value  mem[TEST_WORD][15:0], combinational from storage
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int TEST_WORD   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] test_value
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         count_q, count_d;
    logic               write_q, write_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               resp_err_q, resp_err_d;

    logic [31:0]        mem_q [DEPTH];

    // Decoded view of the incoming request. The upper address bits only feed
    // the error flag; the index is never wrapped.
    logic               req_err;
    logic [IDX_W-1:0]   req_idx;

    // Operation being committed this edge: the captured request normally,
    // the live request when there are no wait states.
    logic               commit;
    logic               cur_write;
    logic [IDX_W-1:0]   cur_idx;
    logic [31:0]        cur_wdata;
    logic               cur_err;
    logic               mem_we;

    assign req_err = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    assign req_idx = req_addr[IDX_W+1:2];

    // Next-state logic for the IDLE -> BUSY -> RESP handshake. The commit
    // block at the bottom overrides the state and response registers on the
    // edge that enters RESP.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        write_d    = write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;
        commit     = 1'b0;
        cur_write  = write_q;
        cur_idx    = idx_q;
        cur_wdata  = wdata_q;
        cur_err    = err_q;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    if (WAIT_CYCLES == 0) begin
                        commit    = 1'b1;
                        cur_write = req_write;
                        cur_idx   = req_idx;
                        cur_wdata = req_wdata;
                        cur_err   = req_err;
                    end else begin
                        state_d = BUSY;
                        count_d = WAIT_M1;
                    end
                end
            end
            BUSY: begin
                if (count_q == 4'd0) begin
                    commit = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d    = IDLE;
                    rdata_d    = '0;
                    resp_err_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load returns the word as it was before this edge; a store or an
        // error response carries zero data.
        if (commit) begin
            state_d    = RESP;
            resp_err_d = cur_err;
            mem_we     = cur_write && !cur_err;
            rdata_d    = (!cur_write && !cur_err) ? mem_q[cur_idx] : '0;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Storage. Reset clears every word, so a store pending at reset is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[cur_idx] <= cur_wdata;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;
    assign test_value = mem_q[TEST_WORD][15:0];

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// ---------------------------------------------------------------------------
// Directed bench for dmem_responder. Instance dut uses WAIT_CYCLES=2 and
// instance dut0 uses WAIT_CYCLES=0; both use DEPTH=64 and TEST_WORD=0 and
// share clock and reset. Expected responses come from a reference memory
// model and are queued when a request is driven, then popped when the DUT
// presents its response.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WAIT2 = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [15:0] test_value;

    logic        req_valid0 = 1'b0, req_write0 = 1'b0, resp_ready0 = 1'b1;
    logic [31:0] req_addr0 = '0, req_wdata0 = '0;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;
    logic [15:0] test_value0;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [32:0] exp_q  [$];
    logic [32:0] exp0_q [$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT2), .TEST_WORD(0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .test_value(test_value)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .TEST_WORD(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0), .test_value(test_value0)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model of one transaction; returns {err, rdata}.
    function automatic logic [32:0] modelAccess(input logic wr, input logic [31:0] addr,
                                                input logic [31:0] wd);
        logic err;
        logic [5:0] idx;
        err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
        idx = addr[7:2];
        if (err) return {1'b1, 32'h0};
        if (wr) begin
            model_mem[idx] = wd;
            return {1'b0, 32'h0};
        end
        return {1'b0, model_mem[idx]};
    endfunction

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_q.delete();
        exp0_q.delete();
    endtask

    // Presents one request to dut while it is in IDLE and returns at the
    // falling edge of cycle t=1 with req_valid dropped.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        checkOutput("ready_before_accept", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        exp_q.push_back(modelAccess(wr, addr, wd));
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hA5A5_A5A5;
    endtask

    // Waits for the response, checks latency and data, optionally stalls
    // resp_ready for stall cycles (pulsing req_valid inside the window), then
    // completes the handshake.
    task automatic waitResponse(input string tag, input int stall);
        int lat;
        logic [32:0] exp;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(WAIT2 + 1));
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        exp = exp_q.pop_front();
        checkOutput({tag, "_rdata"}, resp_rdata, exp[31:0]);
        checkOutput({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp[32]});
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 32'h0;
                req_wdata = 32'h0000_DEAD;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            checkOutput({tag, "_stall_valid"}, {31'b0, resp_valid}, 32'd1);
            checkOutput({tag, "_stall_ready"}, {31'b0, req_ready}, 32'd0);
            checkOutput({tag, "_stall_rdata"}, resp_rdata, exp[31:0]);
            checkOutput({tag, "_stall_err"}, {31'b0, resp_err}, {31'b0, exp[32]});
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput({tag, "_done_valid"}, {31'b0, resp_valid}, 32'd0);
        checkOutput({tag, "_done_ready"}, {31'b0, req_ready}, 32'd1);
        checkOutput({tag, "_done_rdata"}, resp_rdata, 32'd0);
        checkOutput({tag, "_done_err"}, {31'b0, resp_err}, 32'd0);
    endtask

    initial begin
        logic [32:0] exp;
        logic [31:0] stream_addr [4];
        logic        stream_wr   [4];

        // Reset state of both instances.
        doReset();
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("rst_test_value", {16'b0, test_value}, 32'd0);
        checkOutput("rst0_req_ready", {31'b0, req_ready0}, 32'd1);
        checkOutput("rst0_resp_valid", {31'b0, resp_valid0}, 32'd0);

        // Store then load word 0; test_value mirrors word 0.
        applyStimulus(1'b1, 32'h0, 32'h0000_BEEF);
        waitResponse("store_beef", 0);
        checkOutput("test_value_beef", {16'b0, test_value}, 32'h0000_BEEF);
        applyStimulus(1'b0, 32'h0, 32'h0);
        waitResponse("load_beef", 0);

        // Error responses leave memory untouched.
        doReset();
        applyStimulus(1'b0, 32'h6, 32'h0);
        waitResponse("misaligned_load", 0);
        applyStimulus(1'b1, 32'h100, 32'h1111_2222);
        waitResponse("range_store", 0);
        for (int w = 0; w < DEPTH; w++) begin
            applyStimulus(1'b0, 32'(w * 4), 32'h0);
            waitResponse("readback", 0);
        end

        // Response held through a resp_ready stall; a req_valid pulse during
        // RESP must not be accepted or queued.
        applyStimulus(1'b1, 32'h0, 32'h55AA_55AA);
        waitResponse("stall_prep", 0);
        checkOutput("test_value_55aa", {16'b0, test_value}, 32'h0000_55AA);
        applyStimulus(1'b0, 32'h0, 32'h0);
        waitResponse("stall_load", 5);
        repeat (2) begin
            @(negedge clk);
            checkOutput("no_queued_valid", {31'b0, resp_valid}, 32'd0);
            checkOutput("no_queued_ready", {31'b0, req_ready}, 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0);
        waitResponse("after_pulse_load", 0);

        // Zero wait states, req_valid held high: accept every other cycle,
        // response in the cycle after each accept.
        stream_wr   = '{1'b1, 1'b0, 1'b0, 1'b0};
        stream_addr = '{32'h4, 32'h4, 32'h0, 32'h4};
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) @(negedge clk);
            checkOutput("zw_req_ready", {31'b0, req_ready0}, (j % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("zw_resp_valid", {31'b0, resp_valid0}, (j % 2 == 1) ? 32'd1 : 32'd0);
            if (j % 2 == 0) begin
                req_valid0 = 1'b1;
                req_write0 = stream_wr[j/2];
                req_addr0  = stream_addr[j/2];
                req_wdata0 = 32'hC0DE_0001;
                exp0_q.push_back((j == 0) ? 33'h0 : (j == 4) ? 33'h0 : {1'b0, 32'hC0DE_0001});
            end else if (exp0_q.size() != 0) begin
                exp = exp0_q.pop_front();
                checkOutput("zw_rdata", resp_rdata0, exp[31:0]);
                checkOutput("zw_err", {31'b0, resp_err0}, {31'b0, exp[32]});
            end
            if (j == 7) req_valid0 = 1'b0;
        end

        // Reset in the middle of a store discards it and clears memory.
        applyStimulus(1'b1, 32'h14, 32'h1234_5678);
        waitResponse("store_w5", 0);
        applyStimulus(1'b1, 32'h14, 32'hFFFF_FFFF);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_busy_valid", {31'b0, resp_valid}, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_q.delete();
        checkOutput("rst_busy_ready", {31'b0, req_ready}, 32'd1);
        applyStimulus(1'b0, 32'h14, 32'h0);
        waitResponse("load_w5_cleared", 0);

        // Store word 3; word 3 reads back, word 4 stays zero.
        applyStimulus(1'b1, 32'hC, 32'hCAFE_0003);
        waitResponse("store_w3", 0);
        applyStimulus(1'b0, 32'hC, 32'h0);
        waitResponse("load_w3", 0);
        applyStimulus(1'b0, 32'h10, 32'h0);
        waitResponse("load_w4", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
